// File: rtl/div_scheduler_if.sv
// div_scheduler_if
//   Groups the request, response and divider-side signals of div_scheduler.
//   The slave modport is the scheduler's view. The master modport is the
//   surrounding system's view: the two requesters, the response consumer and
//   the divider.
//
//   Requester n (n = 0, 1):
//     reqN_valid  operation offered
//     reqN_ready  operation accepted this cycle
//     reqN_in1    dividend, two's complement
//     reqN_in2    divisor, two's complement
//   Divider:
//     div_in1     registered dividend to the divider
//     div_in2     registered divisor to the divider
//     div_out     registered quotient from the divider
//   Response:
//     resp_valid  response available
//     resp_ready  consumer accepts the response
//     resp_id     requester that issued the operation
//     resp_quot   signed quotient
//     resp_div0   divisor was zero
//   Status:
//     busy        scheduler is not idle
interface div_scheduler_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_in1;
  logic [31:0] req0_in2;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_in1;
  logic [31:0] req1_in2;
  logic [31:0] div_in1;
  logic [31:0] div_in2;
  logic [31:0] div_out;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_quot;
  logic        resp_div0;
  logic        busy;

  modport slave (
    input  req0_valid, req0_in1, req0_in2,
    input  req1_valid, req1_in1, req1_in2,
    input  div_out, resp_ready,
    output req0_ready, req1_ready,
    output div_in1, div_in2,
    output resp_valid, resp_id, resp_quot, resp_div0, busy
  );

  modport master (
    output req0_valid, req0_in1, req0_in2,
    output req1_valid, req1_in1, req1_in2,
    output div_out, resp_ready,
    input  req0_ready, req1_ready,
    input  div_in1, div_in2,
    input  resp_valid, resp_id, resp_quot, resp_div0, busy
  );
endinterface

// File: rtl/div_scheduler.sv
// div_scheduler
//   Shares one multicycle signed divider between two requesters. The
//   scheduler arbitrates round-robin, launches the winner's operands into
//   the divider, waits out the divider's multicycle window, and returns the
//   registered quotient with the requester id over a valid/ready response
//   port. A zero divisor bypasses the divider and returns quotient 0 with
//   resp_div0 set.
//
//   Parameters:
//     DIV_CYCLES  edges from operand launch until div_out settles (2..15);
//                 must match the divider's multicycle constraint
//   Ports:
//     clock       system clock, rising edge
//     reset_n     asynchronous active-low reset
//     bus         div_scheduler_if.slave (requesters, divider, response)
module div_scheduler #(
  parameter int DIV_CYCLES = 4
) (
  input logic           clock,
  input logic           reset_n,
  div_scheduler_if.slave bus
);

  localparam logic [3:0] CNT_INIT = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        lastGrant_q, lastGrant_d;
  logic [31:0] divIn1_q, divIn1_d;
  logic [31:0] divIn2_q, divIn2_d;
  logic        respId_q, respId_d;
  logic [31:0] respQuot_q, respQuot_d;
  logic        respDiv0_q, respDiv0_d;

  logic        anyValid;
  logic        grant;
  logic [31:0] selIn1;
  logic [31:0] selIn2;

  // Round-robin pick: on a tie the requester that did not win last time
  // goes next; otherwise whichever requester is valid wins.
  always_comb begin
    anyValid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~lastGrant_q;
    end else begin
      grant = bus.req1_valid;
    end
    selIn1 = grant ? bus.req1_in1 : bus.req0_in1;
    selIn2 = grant ? bus.req1_in2 : bus.req0_in2;
  end

  // Next-state and output logic. The divider operands only change on an
  // accept, so they stay stable across the multicycle window. Ready is
  // masked by reset_n so nothing looks accepted while reset is held.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lastGrant_d    = lastGrant_q;
    divIn1_d       = divIn1_q;
    divIn2_d       = divIn2_q;
    respId_d       = respId_q;
    respQuot_d     = respQuot_q;
    respDiv0_d     = respDiv0_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.resp_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (anyValid && reset_n) begin
          bus.req0_ready = ~grant;
          bus.req1_ready = grant;
          divIn1_d       = selIn1;
          divIn2_d       = selIn2;
          respId_d       = grant;
          lastGrant_d    = grant;
          if (selIn2 != 32'd0) begin
            cnt_d   = CNT_INIT;
            state_d = RUN;
          end else begin
            // A zero divisor never uses the divider result.
            respQuot_d = 32'd0;
            respDiv0_d = 1'b1;
            state_d    = DONE;
          end
        end
      end
      RUN: begin
        // The count reaching zero marks the edge where div_out has settled.
        if (cnt_q == 4'd0) begin
          respQuot_d = bus.div_out;
          respDiv0_d = 1'b0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. last grant resets to 1 so requester 0
  // wins the first tie.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      lastGrant_q <= 1'b1;
      divIn1_q    <= 32'd0;
      divIn2_q    <= 32'd0;
      respId_q    <= 1'b0;
      respQuot_q  <= 32'd0;
      respDiv0_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lastGrant_q <= lastGrant_d;
      divIn1_q    <= divIn1_d;
      divIn2_q    <= divIn2_d;
      respId_q    <= respId_d;
      respQuot_q  <= respQuot_d;
      respDiv0_q  <= respDiv0_d;
    end
  end

  assign bus.div_in1   = divIn1_q;
  assign bus.div_in2   = divIn2_q;
  assign bus.resp_id   = respId_q;
  assign bus.resp_quot = respQuot_q;
  assign bus.resp_div0 = respDiv0_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_div_scheduler.sv
// tb_div_scheduler
//   Testbench for div_scheduler. It models the shared divider as a
//   registered signed divide and checks the scheduler against hand-computed
//   vectors, a few multi-cycle sequences and randomized operations. The
//   randomized operations are predicted by a round-robin and
//   quotient-by-magnitude reference model.
module tb_div_scheduler;

  localparam int DIV_CYCLES = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  int   testsRun    = 0;
  int   testsFailed = 0;
  logic rrLast      = 1'b1;

  always #5 clock = ~clock;

  div_scheduler_if bus();

  div_scheduler #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Divider stand-in: registered truncating signed divide. A zero divisor
  // yields a junk value so that a design using it would be caught.
  function automatic logic [31:0] dividerModel(input logic [31:0] a, input logic [31:0] b);
    longint q;
    if (b == 32'd0) return 32'hDEAD_BEEF;
    q = longint'($signed(a)) / longint'($signed(b));
    return q[31:0];
  endfunction

  always @(posedge clock) bus.div_out <= dividerModel(bus.div_in1, bus.div_in2);

  // Reference quotient: divide the magnitudes, then apply the sign of the
  // result, and keep the low 32 bits.
  function automatic logic [31:0] refQuot(input logic [31:0] a, input logic [31:0] b);
    longint ma, mb, q;
    if (b == 32'd0) return 32'd0;
    ma = a[31] ? -longint'($signed(a)) : longint'($signed(a));
    mb = b[31] ? -longint'($signed(b)) : longint'($signed(b));
    q  = ma / mb;
    if (a[31] ^ b[31]) q = -q;
    return q[31:0];
  endfunction

  function automatic logic pickGrant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic applyReset();
    @(posedge clock); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.resp_ready = 1'b0;
    reset_n        = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    rrLast  = 1'b1;
  endtask

  // Runs one operation end to end. Inputs change and outputs are sampled 1
  // time unit after a rising edge. Valids stay asserted through RUN so that
  // ready can be shown to stay low. With press set, both valids are held
  // during the DONE hold and remain asserted on return.
  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [31:0] a0, input logic [31:0] b0,
                               input logic [31:0] a1, input logic [31:0] b1,
                               input logic expId, input logic [31:0] expQuot,
                               input logic expDiv0, input int hold, input bit press,
                               input string tag);
    int          waited;
    int          runCycles;
    bit          runOk;
    bit          stable;
    logic [31:0] opA, opB;
    @(posedge clock); #1;
    bus.req0_valid = v0; bus.req0_in1 = a0; bus.req0_in2 = b0;
    bus.req1_valid = v1; bus.req1_in1 = a1; bus.req1_in2 = b1;
    bus.resp_ready = 1'b0;
    #1;
    waited = 0;
    while (!(bus.req0_ready || bus.req1_ready) && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    if (waited >= 20) begin
      checkBit({tag, "_acceptTimeout"}, 1'b0, 1'b1);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      return;
    end
    checkBit({tag, "_grant"}, bus.req1_ready, expId);
    checkBit({tag, "_oneReady"}, bus.req0_ready & bus.req1_ready, 1'b0);
    opA    = expId ? a1 : a0;
    opB    = expId ? b1 : b0;
    rrLast = expId;
    @(posedge clock); #1;
    checkOutput({tag, "_divIn1"}, bus.div_in1, opA);
    checkOutput({tag, "_divIn2"}, bus.div_in2, opB);
    runCycles = 0;
    runOk     = 1'b1;
    while (!bus.resp_valid && runCycles < 40) begin
      if (bus.req0_ready || bus.req1_ready || !bus.busy) runOk = 1'b0;
      @(posedge clock); #1;
      runCycles++;
    end
    if (!press) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
    checkBit({tag, "_runReadyLow"}, runOk, 1'b1);
    checkOutput({tag, "_latency"}, 32'(runCycles), expDiv0 ? 32'd0 : 32'(DIV_CYCLES + 1));
    checkOutput({tag, "_quot"}, bus.resp_quot, expQuot);
    checkBit({tag, "_id"}, bus.resp_id, expId);
    checkBit({tag, "_div0"}, bus.resp_div0, expDiv0);
    checkBit({tag, "_busyDone"}, bus.busy, 1'b1);
    checkOutput({tag, "_divIn1Stable"}, bus.div_in1, opA);
    checkOutput({tag, "_divIn2Stable"}, bus.div_in2, opB);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (press) begin
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
      end
      @(posedge clock); #1;
      if (!bus.resp_valid || bus.resp_quot !== expQuot || bus.resp_id !== expId ||
          bus.resp_div0 !== expDiv0 || !bus.busy || bus.req0_ready || bus.req1_ready ||
          bus.div_in1 !== opA || bus.div_in2 !== opB)
        stable = 1'b0;
    end
    if (hold > 0) checkBit({tag, "_heldStable"}, stable, 1'b1);
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    bus.resp_ready = 1'b0;
    checkBit({tag, "_idleAfterHandshake"}, bus.busy, 1'b0);
  endtask

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        expId;
    logic [31:0] expQuot;
    logic        expDiv0;
    int          hold;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] randDividend();
    int kind = $urandom_range(0, 5);
    if (kind == 0) return 32'h8000_0000;
    if (kind == 1) return 32'($urandom_range(0, 40)) - 32'd20;
    return $urandom;
  endfunction

  function automatic logic [31:0] randDivisor();
    int kind = $urandom_range(0, 7);
    if (kind == 0) return 32'd0;
    if (kind == 1) return 32'hFFFF_FFFF;
    if (kind <= 4) return ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 20))
                                                     : -32'($urandom_range(1, 20));
    return $urandom;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          sel;
    logic        v0, v1, g;
    logic [31:0] a0, b0, a1, b1;
    int          acceptCyc[$];
    logic        grantQ[$];
    logic        respIdQ[$];
    logic [31:0] respQuotQ[$];
    bit          noResp;

    // Expected values below are worked out by hand in table order from a
    // fresh reset (requester 0 wins the first tie).
    vecs[0] = '{1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFD, 1'b0, 0};
    vecs[1] = '{1'b0, 1'b1, 32'd0, 32'd0, 32'd5, 32'd0, 1'b1, 32'd0, 1'b1, 0};
    vecs[2] = '{1'b1, 1'b1, 32'd100, 32'd7, 32'hFFFF_FF9C, 32'd7, 1'b0, 32'd14, 1'b0, 0};
    vecs[3] = '{1'b1, 1'b1, 32'd100, 32'd7, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 1'b0, 0};
    vecs[4] = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 32'h8000_0000, 1'b0, 2};
    vecs[5] = '{1'b0, 1'b1, 32'd0, 32'd0, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 1'b0, 0};
    vecs[6] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd0, 32'd0, 1'b0, 32'd2, 1'b0, 1};
    vecs[7] = '{1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd5, 1'b1, 32'd0, 1'b0, 0};
    vecs[8] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1, 0};
    vecs[9] = '{1'b1, 1'b1, 32'h7FFF_FFFF, 32'd2, 32'd13, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFD, 1'b0, 0};

    bus.req0_valid = 1'b1; bus.req0_in1 = 32'd1; bus.req0_in2 = 32'd1;
    bus.req1_valid = 1'b1; bus.req1_in1 = 32'd1; bus.req1_in2 = 32'd1;
    bus.resp_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkBit("rstReady0", bus.req0_ready, 1'b0);
    checkBit("rstReady1", bus.req1_ready, 1'b0);
    checkBit("rstBusy", bus.busy, 1'b0);
    checkBit("rstRespValid", bus.resp_valid, 1'b0);
    checkOutput("rstDivIn1", bus.div_in1, 32'd0);
    checkOutput("rstDivIn2", bus.div_in2, 32'd0);
    checkOutput("rstQuot", bus.resp_quot, 32'd0);
    applyReset();

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                    vecs[i].expId, vecs[i].expQuot, vecs[i].expDiv0, vecs[i].hold, 1'b0,
                    $sformatf("vec%0d", i));
    end

    // Backpressure with both requesters waiting: no grant during DONE, and
    // the waiting tie is granted in the first IDLE cycle after the handshake.
    applyStimulus(1'b1, 1'b0, 32'd9, 32'd3, 32'd0, 32'd0, 1'b0, 32'd3, 1'b0, 20, 1'b1, "bp");
    checkBit("bpAcceptNextCycle1", bus.req1_ready, pickGrant(1'b1, 1'b1, rrLast));
    checkBit("bpAcceptNextCycle0", bus.req0_ready, ~pickGrant(1'b1, 1'b1, rrLast));
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    noResp = 1'b1;
    repeat (6) begin
      @(posedge clock); #1;
      if (bus.busy || bus.resp_valid) noResp = 1'b1 & 1'b0;
    end
    checkBit("dropNoLaunch", noResp, 1'b1);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(1, 3);
      v0  = sel[0];
      v1  = sel[1];
      a0  = randDividend(); b0 = randDivisor();
      a1  = randDividend(); b1 = randDivisor();
      g   = pickGrant(v0, v1, rrLast);
      applyStimulus(v0, v1, a0, b0, a1, b1, g, refQuot(g ? a1 : a0, g ? b1 : b0),
                    (g ? b1 : b0) == 32'd0, $urandom_range(0, 3), 1'b0, $sformatf("rand%0d", i));
    end

    // Reset two cycles into RUN discards the operation.
    @(posedge clock); #1;
    bus.req1_valid = 1'b1; bus.req1_in1 = 32'd10; bus.req1_in2 = 32'd3;
    @(posedge clock); #1;
    bus.req1_valid = 1'b0;
    @(posedge clock); #1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    checkBit("midRstBusy", bus.busy, 1'b0);
    checkBit("midRstRespValid", bus.resp_valid, 1'b0);
    checkBit("midRstReady0", bus.req0_ready, 1'b0);
    checkBit("midRstReady1", bus.req1_ready, 1'b0);
    checkOutput("midRstDivIn1", bus.div_in1, 32'd0);
    checkOutput("midRstDivIn2", bus.div_in2, 32'd0);
    checkOutput("midRstQuot", bus.resp_quot, 32'd0);
    checkBit("midRstId", bus.resp_id, 1'b0);
    checkBit("midRstDiv0", bus.resp_div0, 1'b0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    rrLast  = 1'b1;
    noResp  = 1'b1;
    repeat (10) begin
      @(posedge clock); #1;
      if (bus.resp_valid || bus.busy) noResp = 1'b0;
    end
    checkBit("midRstNoStale", noResp, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'd20, 32'hFFFF_FFFA, 32'd1, 32'd1, 1'b0, 32'hFFFF_FFFD, 1'b0,
                  0, 1'b0, "postRst");

    // Continuous contention with the consumer always ready: grants alternate
    // and a new operation starts every DIV_CYCLES+3 cycles.
    applyReset();
    bus.req0_valid = 1'b1; bus.req0_in1 = 32'd100;        bus.req0_in2 = 32'd7;
    bus.req1_valid = 1'b1; bus.req1_in1 = 32'hFFFF_FF9C;  bus.req1_in2 = 32'd7;
    bus.resp_ready = 1'b1;
    #1;
    for (int c = 0; c < 34; c++) begin
      if (bus.req0_ready || bus.req1_ready) begin
        acceptCyc.push_back(c);
        grantQ.push_back(bus.req1_ready);
      end
      if (bus.resp_valid) begin
        respIdQ.push_back(bus.resp_id);
        respQuotQ.push_back(bus.resp_quot);
      end
      @(posedge clock); #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    checkBit("rrEnoughGrants", acceptCyc.size() >= 4, 1'b1);
    checkBit("rrEnoughResps", respIdQ.size() >= 4, 1'b1);
    if (acceptCyc.size() >= 4 && respIdQ.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        checkBit($sformatf("rrGrant%0d", k), grantQ[k], 1'(k % 2));
        checkBit($sformatf("rrRespId%0d", k), respIdQ[k], 1'(k % 2));
        checkOutput($sformatf("rrRespQuot%0d", k), respQuotQ[k],
                    (k % 2 == 0) ? 32'd14 : 32'hFFFF_FFF2);
        if (k > 0)
          checkOutput($sformatf("rrSpacing%0d", k), 32'(acceptCyc[k] - acceptCyc[k-1]),
                      32'(DIV_CYCLES + 3));
      end
    end
    applyReset();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
